secuenciador_alerta: RTL

- FSM controller that sequences read → decide → alert for the cabin-temperature monitor.
- Consumes the debounced/synchronized temperature, presence and ignition signals plus the OR-ed data-ready pulse from the anti-bounce registers.
- Drives ventilation and alarm with hysteresis and minimum hold times.
- Exports its state code to the 7-segment status digit.

---
 rtl/secuenciador_alerta_if.sv | 23 ++
 rtl/secuenciador_alerta.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/secuenciador_alerta_if.sv
// Signal bundle between the cabin-temperature front end and the alert sequencer.
// The master side drives the synchronized sensor inputs; the slave side drives actuators and status.
interface secuenciador_alerta_if;
  logic       dato_listo;
  logic [4:0] temperatura;
  logic       presencia;
  logic       ignicion;
  logic       ventilacion;
  logic       alarma;
  logic       peligro;
  logic [1:0] estados;
  logic       tick;

  modport master (
    output dato_listo, temperatura, presencia, ignicion,
    input  ventilacion, alarma, peligro, estados, tick
  );

  modport slave (
    input  dato_listo, temperatura, presencia, ignicion,
    output ventilacion, alarma, peligro, estados, tick
  );
endinterface

// File: rtl/secuenciador_alerta.sv
// Read -> decide -> alert sequencer for the cabin-temperature monitor.
// Drives fan and alarm with hysteresis and minimum hold times; exports its state code.
module secuenciador_alerta #(
  parameter int T_ALTA       = 25,
  parameter int T_BAJA       = 22,
  parameter int T_CRIT       = 30,
  parameter int TICK_DIV     = 50000000,
  parameter int MIN_VENT_S   = 10,
  parameter int ALARM_HOLD_S = 5
) (
  input logic clk,
  input logic rst,
  secuenciador_alerta_if.slave bus
);

  localparam int TIMER_MAX = (MIN_VENT_S > ALARM_HOLD_S) ? MIN_VENT_S : ALARM_HOLD_S;
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam int CW = $clog2(TICK_DIV);

  localparam logic [4:0]    T_ALTA_V   = 5'(T_ALTA);
  localparam logic [4:0]    T_BAJA_V   = 5'(T_BAJA);
  localparam logic [4:0]    T_CRIT_V   = 5'(T_CRIT);
  localparam logic [TW-1:0] VENT_LOAD  = TW'(MIN_VENT_S);
  localparam logic [TW-1:0] ALARM_LOAD = TW'(ALARM_HOLD_S);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LEER    = 2'b01,
    DECIDIR = 2'b10,
    ALERTA  = 2'b11
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          tick_q;
  logic          vent_q, vent_n, alarm_q, alarm_n, pel_q, pel_n, pend_q, pend_n;
  logic [4:0]    s_temp, s_temp_n;
  logic          s_pres, s_pres_n, s_ign, s_ign_n;
  logic [TW-1:0] vent_t, vent_t_n, alarm_t, alarm_t_n;
  logic          sample, evt, danger, vent_req;
  logic [4:0]    eff_temp;
  logic          eff_pres, eff_ign, eff_danger;

  // tick_q is registered one cycle ahead so it is high exactly while cnt sits at its last value
  assign cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      tick_q <= (cnt_n == CNT_LAST);
    end
  end

  // In ALERTA a sample taken this cycle must already steer the exit decision
  assign evt        = bus.dato_listo | tick_q;
  assign eff_temp   = evt ? bus.temperatura : s_temp;
  assign eff_pres   = evt ? bus.presencia   : s_pres;
  assign eff_ign    = evt ? bus.ignicion    : s_ign;
  assign eff_danger = (eff_temp >= T_CRIT_V) & eff_pres & ~eff_ign;
  assign danger     = (s_temp >= T_CRIT_V) & s_pres & ~s_ign;
  assign vent_req   = (s_temp >= T_ALTA_V) | (vent_q & (s_temp > T_BAJA_V));

  always_comb begin
    state_n   = state;
    vent_n    = vent_q;
    alarm_n   = alarm_q;
    pel_n     = pel_q;
    pend_n    = pend_q;
    sample    = 1'b0;
    vent_t_n  = (tick_q && vent_t != '0) ? vent_t - TW'(1) : vent_t;
    alarm_t_n = (tick_q && alarm_t != '0) ? alarm_t - TW'(1) : alarm_t;

    if (bus.dato_listo && state != LEER) pend_n = 1'b1;

    case (state)
      IDLE: state_n = LEER;
      LEER: begin
        if (bus.dato_listo || pend_q || tick_q) begin
          sample  = 1'b1;
          pend_n  = 1'b0;
          state_n = DECIDIR;
        end
      end
      DECIDIR: begin
        if (danger) begin
          pel_n     = 1'b1;
          alarm_n   = 1'b1;
          vent_n    = 1'b1;
          alarm_t_n = ALARM_LOAD;
          vent_t_n  = VENT_LOAD;
          state_n   = ALERTA;
        end else begin
          pel_n   = 1'b0;
          state_n = LEER;
          if (vent_req && !vent_q) begin
            vent_n   = 1'b1;
            vent_t_n = VENT_LOAD;
          end else if (!vent_req && vent_q && vent_t == '0) begin
            vent_n = 1'b0;
          end
        end
      end
      ALERTA: begin
        alarm_n = 1'b1;
        vent_n  = 1'b1;
        sample  = evt;
        if (eff_ign || (alarm_t == '0 && !eff_danger)) begin
          alarm_n = 1'b0;
          pel_n   = 1'b0;
          state_n = LEER;
        end
      end
      default: state_n = IDLE;
    endcase

    s_temp_n = sample ? bus.temperatura : s_temp;
    s_pres_n = sample ? bus.presencia   : s_pres;
    s_ign_n  = sample ? bus.ignicion    : s_ign;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vent_q  <= 1'b0;
      alarm_q <= 1'b0;
      pel_q   <= 1'b0;
      pend_q  <= 1'b0;
      s_temp  <= '0;
      s_pres  <= 1'b0;
      s_ign   <= 1'b0;
      vent_t  <= '0;
      alarm_t <= '0;
    end else begin
      state   <= state_n;
      vent_q  <= vent_n;
      alarm_q <= alarm_n;
      pel_q   <= pel_n;
      pend_q  <= pend_n;
      s_temp  <= s_temp_n;
      s_pres  <= s_pres_n;
      s_ign   <= s_ign_n;
      vent_t  <= vent_t_n;
      alarm_t <= alarm_t_n;
    end
  end

  assign bus.ventilacion = vent_q;
  assign bus.alarma      = alarm_q;
  assign bus.peligro     = pel_q;
  assign bus.estados     = state;
  assign bus.tick        = tick_q;

endmodule
